// File: rtl/frame_seq_pkg.sv
// Shared definitions for the single-frame convolution sequencer: state
// encoding, frame-size derivations and the counter width helper.
`ifndef FRAME_SEQ_PKG_SV
`define FRAME_SEQ_PKG_SV

`define FRAME_PIXELS(w, h) ((w) * (h))
`define OUT_PIXELS(w, h, k) (((w) - (k) + 1) * ((h) - (k) + 1))

package frame_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PROCESS = 2'd2,
        ST_UNLOAD  = 2'd3
    } state_e;

    // Bits needed to hold 'value' itself, so a terminal count always fits.
    function automatic int clogb2(input int value);
        int bits = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            bits++;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

`endif

// File: rtl/px_counter.sv
// Pixel counter with synchronous clear and a terminal-count flag; it holds at
// the terminal count instead of wrapping.
module px_counter #(
    parameter int WIDTH    = 7,
    parameter int TERMINAL = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_incr,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_last
);

    localparam logic [WIDTH-1:0] TERM_C = WIDTH'(TERMINAL);
    localparam logic [WIDTH-1:0] LAST_C = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_incr && (cnt_q != TERM_C)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    // High while the increment about to be taken is the final one.
    assign o_last = (cnt_q == LAST_C);

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: loads a host frame into the source BRAM, steers convolution
// results into the destination BRAM, then serves host reads of the result.
module frame_seq_ctrl
    import frame_seq_pkg::*;
#(
    parameter int RAM_WIDTH    = 8,
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10,
    parameter int KERNEL_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_host_valid,
    input  logic [RAM_WIDTH-1:0] i_host_data,
    input  logic                 i_host_rd_req,
    output logic [RAM_WIDTH-1:0] o_host_data,
    output logic                 o_host_data_valid,
    output logic                 o_src_load_valid,
    output logic [RAM_WIDTH-1:0] o_src_data,
    output logic                 o_src_read_valid,
    input  logic                 i_conv_valid,
    input  logic [RAM_WIDTH-1:0] i_conv_data,
    output logic                 o_dst_load_valid,
    output logic [RAM_WIDTH-1:0] o_dst_data,
    output logic                 o_dst_read_valid,
    input  logic [RAM_WIDTH-1:0] i_dst_data,
    output logic [1:0]           o_state,
    output logic                 o_frame_done,
    output logic                 o_overrun
);

    localparam int FRAME_PIXELS = `FRAME_PIXELS(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int OUT_PIXELS   = `OUT_PIXELS(IMAGE_WIDTH, IMAGE_HEIGHT, KERNEL_WIDTH);
    localparam int CNT_W        = clogb2(FRAME_PIXELS);

    localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] OUT_C   = CNT_W'(OUT_PIXELS);

    state_e               state_q, state_d;
    logic                 src_load_valid_q, src_load_valid_d;
    logic [RAM_WIDTH-1:0] src_data_q, src_data_d;
    logic                 src_read_valid_q, src_read_valid_d;
    logic                 dst_load_valid_q, dst_load_valid_d;
    logic [RAM_WIDTH-1:0] dst_data_q, dst_data_d;
    logic                 dst_read_valid_q, dst_read_valid_d;
    logic                 rd_final_q, rd_final_d;
    logic [RAM_WIDTH-1:0] host_data_q, host_data_d;
    logic                 host_data_valid_q, host_data_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overrun_q, overrun_d;

    logic [CNT_W-1:0] load_cnt, conv_cnt, rd_cnt;
    logic             load_last, conv_last, rd_last;
    logic             in_idle, in_load, in_proc, in_unload;
    logic             load_acc, conv_acc, rd_acc;

    assign in_idle   = (state_q == ST_IDLE);
    assign in_load   = (state_q == ST_LOAD);
    assign in_proc   = (state_q == ST_PROCESS);
    assign in_unload = (state_q == ST_UNLOAD);

    // Accept guards also stop a counter that has reached its terminal count.
    assign load_acc = i_host_valid && (in_idle || in_load) && (load_cnt != FRAME_C);
    assign conv_acc = i_conv_valid && in_proc && (conv_cnt != OUT_C);
    assign rd_acc   = i_host_rd_req && in_unload && (rd_cnt != OUT_C);

    px_counter #(.WIDTH(CNT_W), .TERMINAL(FRAME_PIXELS)) u_load_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (!in_load && !load_acc),
        .i_incr  (load_acc),
        .o_cnt   (load_cnt),
        .o_last  (load_last)
    );

    px_counter #(.WIDTH(CNT_W), .TERMINAL(OUT_PIXELS)) u_conv_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (!in_proc),
        .i_incr  (conv_acc),
        .o_cnt   (conv_cnt),
        .o_last  (conv_last)
    );

    px_counter #(.WIDTH(CNT_W), .TERMINAL(OUT_PIXELS)) u_rd_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (!in_unload),
        .i_incr  (rd_acc),
        .o_cnt   (rd_cnt),
        .o_last  (rd_last)
    );

    always_comb begin
        state_d           = state_q;
        src_load_valid_d  = 1'b0;
        src_data_d        = src_data_q;
        dst_load_valid_d  = 1'b0;
        dst_data_d        = dst_data_q;
        dst_read_valid_d  = rd_acc;
        rd_final_d        = rd_acc && rd_last;
        host_data_valid_d = dst_read_valid_q;
        host_data_d       = dst_read_valid_q ? i_dst_data : host_data_q;
        frame_done_d      = dst_read_valid_q && rd_final_q;
        overrun_d         = overrun_q
                          | (i_host_valid && (in_proc || in_unload))
                          | (i_conv_valid && !in_proc);

        if (load_acc) begin
            src_load_valid_d = 1'b1;
            src_data_d       = i_host_data;
            if (in_idle) state_d = ST_LOAD;
            if (load_last) state_d = ST_PROCESS;
        end

        if (conv_acc) begin
            dst_load_valid_d = 1'b1;
            dst_data_d       = i_conv_data;
            if (conv_last) state_d = ST_UNLOAD;
        end

        // Leave one cycle after the final pixel reaches the host.
        if (in_unload && frame_done_q) begin
            state_d = ST_IDLE;
        end

        src_read_valid_d = (state_d == ST_PROCESS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            src_load_valid_q  <= 1'b0;
            src_data_q        <= '0;
            src_read_valid_q  <= 1'b0;
            dst_load_valid_q  <= 1'b0;
            dst_data_q        <= '0;
            dst_read_valid_q  <= 1'b0;
            rd_final_q        <= 1'b0;
            host_data_q       <= '0;
            host_data_valid_q <= 1'b0;
            frame_done_q      <= 1'b0;
            overrun_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            src_load_valid_q  <= src_load_valid_d;
            src_data_q        <= src_data_d;
            src_read_valid_q  <= src_read_valid_d;
            dst_load_valid_q  <= dst_load_valid_d;
            dst_data_q        <= dst_data_d;
            dst_read_valid_q  <= dst_read_valid_d;
            rd_final_q        <= rd_final_d;
            host_data_q       <= host_data_d;
            host_data_valid_q <= host_data_valid_d;
            frame_done_q      <= frame_done_d;
            overrun_q         <= overrun_d;
        end
    end

    assign o_state           = state_q;
    assign o_src_load_valid  = src_load_valid_q;
    assign o_src_data        = src_data_q;
    assign o_src_read_valid  = src_read_valid_q;
    assign o_dst_load_valid  = dst_load_valid_q;
    assign o_dst_data        = dst_data_q;
    assign o_dst_read_valid  = dst_read_valid_q;
    assign o_host_data       = host_data_q;
    assign o_host_data_valid = host_data_valid_q;
    assign o_frame_done      = frame_done_q;
    assign o_overrun         = overrun_q;

endmodule
